// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, bus widths and the
// captured request record.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              write;
  } mem_req_t;

endpackage

// File: rtl/sram_bytewrite.sv
// Word-wide storage with per-byte-lane synchronous write and registered read.
// Contents are deliberately not reset.
module sram_bytewrite
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states,
// then a held response until the initiator takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  mem_state_t        state, stateNext;
  mem_req_t          req;
  logic [7:0]        cnt;
  logic              accessEn;
  logic              reqErr;
  logic              rdSel;
  logic [STRB_W-1:0] sramWe;
  logic [WORD_W-1:0] sramRdata;

  assign reqErr = (req.addr[1:0] != 2'b00) ||
                  ({2'b00, req.addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS));
  assign sramWe = (req.write && !reqErr) ? req.wstrb : '0;

  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accessEn  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = resetn;
        if (req_valid) stateNext = BUSY;
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          accessEn  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req     <= '0;
      cnt     <= '0;
      rdSel   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        req <= '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb, write: req_write};
        cnt <= 8'(WAIT_CYCLES);
      end else if (state == BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (accessEn) begin
        rdSel   <= !req.write && !reqErr;
        rsp_err <= reqErr;
      end else if (state == RESP && rsp_ready) begin
        rdSel   <= 1'b0;
        rsp_err <= 1'b0;
      end
    end
  end

  // The SRAM read register only updates on an access, so gating it with a
  // resettable select yields a registered, reset-to-zero rsp_rdata.
  assign rsp_rdata = rdSel ? sramRdata : '0;

  sram_bytewrite #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) uSram (
    .clk  (clk),
    .en   (accessEn),
    .we   (sramWe),
    .addr (req.addr[2 +: AW]),
    .wdata(req.wdata),
    .rdata(sramRdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a transaction-level reference model
// checked every cycle, plus literal expectations per transaction.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, access performed
  // WAITC+1 edges after the accept, response held until taken.
  logic [31:0] mdlMem [DEPTH];
  bit          pending = 0;
  bit          haveRsp = 0;
  int unsigned age = 0;
  bit          mWr;
  logic [31:0] mAddr, mData;
  logic [3:0]  mStrb;
  logic [31:0] expData = '0;
  bit          expErr = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending = 0;
      haveRsp = 0;
    end else if (haveRsp) begin
      if (rsp_ready) begin
        pending = 0;
        haveRsp = 0;
      end
    end else if (pending) begin
      age++;
      if (age == WAITC + 1) begin
        haveRsp = 1;
        if (mAddr[1:0] != 2'b00 || (mAddr >> 2) >= DEPTH) begin
          expErr  = 1;
          expData = 0;
        end else begin
          expErr = 0;
          if (mWr) begin
            expData = 0;
            for (int b = 0; b < 4; b++)
              if (mStrb[b]) mdlMem[mAddr >> 2][8*b +: 8] = mData[8*b +: 8];
          end else begin
            expData = mdlMem[mAddr >> 2];
          end
        end
      end
    end else if (req_valid) begin
      pending = 1;
      age     = 0;
      mWr     = req_write;
      mAddr   = req_addr;
      mData   = req_wdata;
      mStrb   = req_wstrb;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_req_ready", {31'b0, req_ready}, 0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", {31'b0, rsp_err}, 0);
    end else begin
      check("mdl_req_ready", {31'b0, req_ready}, {31'b0, !pending});
      check("mdl_rsp_valid", {31'b0, rsp_valid}, {31'b0, haveRsp});
      if (haveRsp) begin
        check("mdl_rsp_rdata", rsp_rdata, expData);
        check("mdl_rsp_err", {31'b0, rsp_err}, {31'b0, expErr});
      end
    end
  end

  task automatic waitReady(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept_timeout"}, {31'b0, req_ready}, 1);
  endtask

  task automatic waitRspValid(input string name, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_rsp_timeout"}, {31'b0, rsp_valid}, 1);
  endtask

  task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  task automatic txn(input string name, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] expD, input bit expE);
    int lat;
    @(negedge clk);
    rsp_ready = 1;
    drive(wr, a, d, s);
    waitReady(name);
    @(posedge clk);
    #1 req_valid = 0;
    waitRspValid(name, lat);
    check({name, "_latency"}, lat, 3);
    check({name, "_rdata"}, rsp_rdata, expD);
    check({name, "_err"}, {31'b0, rsp_err}, {31'b0, expE});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    #2;
    check("reset_req_ready", {31'b0, req_ready}, 0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", {31'b0, rsp_err}, 0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1;
    #1 check("release_req_ready", {31'b0, req_ready}, 1);

    txn("wr_full", 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
    txn("rd_full", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    txn("wr_part", 1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 0);
    txn("rd_part", 0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 0);
    txn("wr_misal", 1, 32'h12, 32'h11111111, 4'b1111, 32'h0, 1);
    txn("rd_after_misal", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 0);
    txn("wr_nostrb", 1, 32'h10, 32'h55555555, 4'b0000, 32'h0, 0);
    txn("rd_after_nostrb", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 0);
    txn("rd_oor", 0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1);
    txn("wr_top", 1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
    txn("rd_top", 0, 32'hFFC, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
    txn("wr_hi_oor", 1, 32'h8000_0010, 32'h99999999, 4'b1111, 32'h0, 1);
    txn("rd_after_hi_oor", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 0);

    // Back-pressure with a competing request held on the bus.
    @(negedge clk);
    rsp_ready = 0;
    drive(0, 32'h10, 32'h0, 4'b0000);
    waitReady("bp");
    @(posedge clk);
    #1 drive(1, 32'h10, 32'hFFFFFFFF, 4'b1111);
    waitRspValid("bp", lat);
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'b0, rsp_valid}, 1);
      check("bp_hold_rdata", rsp_rdata, 32'hDEADBEAA);
      check("bp_hold_err", {31'b0, rsp_err}, 0);
      check("bp_hold_req_ready", {31'b0, req_ready}, 0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, rsp_valid}, 0);
    check("bp_release_req_ready", {31'b0, req_ready}, 1);
    txn("rd_after_bp", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 0);

    // Reset one cycle after accepting a write.
    txn("wr_zero20", 1, 32'h20, 32'h0, 4'b1111, 32'h0, 0);
    @(negedge clk);
    drive(1, 32'h20, 32'h12345678, 4'b1111);
    waitReady("rst_wr");
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 resetn = 0;
    #1;
    check("midrst_req_ready", {31'b0, req_ready}, 0);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_rsp_err", {31'b0, rsp_err}, 0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1;
    #1 check("midrst_release_ready", {31'b0, req_ready}, 1);
    txn("rd_after_rst", 0, 32'h20, 32'h0, 4'b0000, 32'h0, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
